// File: rtl/fp_mac_dot_seq.sv
// Dot-product sequencer for one fp_mac: issues (A,B,acc) triples one at a time
// and folds each fp_mac result back into the accumulator.
module fp_mac_dot_seq #(
  parameter int MAC_LAT = 3,
  parameter int LEN_W   = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] vec_len,
  input  logic [31:0]      init_acc,
  input  logic             in_valid,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             in_ready,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  output logic [31:0]      mac_c,
  input  logic [31:0]      mac_y,
  output logic             out_valid,
  output logic [31:0]      out_data,
  input  logic             out_ready,
  output logic             busy
);

  localparam int TW = $clog2(MAC_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  state_e           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count_q;
  logic [TW-1:0]    timer_q;
  logic [31:0]      acc_q;
  logic [15:0]      mac_a_q;
  logic [15:0]      mac_b_q;
  logic [31:0]      mac_c_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      len_q       <= '0;
      count_q     <= '0;
      timer_q     <= '0;
      acc_q       <= '0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_c_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (abort) begin
      // Operands and accumulator survive; any result still in fp_mac is dropped.
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            len_q   <= vec_len;
            acc_q   <= init_acc;
            count_q <= '0;
            busy_q  <= 1'b1;
            if (vec_len == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q    <= ISSUE;
              in_ready_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (in_valid) begin
            mac_a_q    <= in_a;
            mac_b_q    <= in_b;
            mac_c_q    <= acc_q;
            count_q    <= count_q + LEN_W'(1);
            timer_q    <= TW'(MAC_LAT);
            state_q    <= WAIT;
            in_ready_q <= 1'b0;
          end
        end
        WAIT: begin
          if (timer_q == TW'(1)) begin
            acc_q   <= mac_y;
            timer_q <= '0;
            if (count_q == len_q) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q    <= ISSUE;
              in_ready_q <= 1'b1;
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = acc_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_c     = mac_c_q;

endmodule
